// File: rtl/rf_pkg.sv
// Shared register-file types and sizing for decode, writeback and the regfile.
// No logic; defaults only, instances may override widths through parameters.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int RF_AW = addr_w(RF_NREGS);

    typedef logic [RF_XLEN-1:0] xword_t;
    typedef logic [RF_AW-1:0]   raddr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard for multi-cycle producers, with per-port busy lookup.
// Latency: set/clear visible one edge later; rbusy/busy_any combinational from state.
// Backpressure: none here; decode stalls on rbusy.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic              wb_clr,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    output logic              busy_any
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear before set so a new producer issued on the completing edge stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (we && wb_clr) begin
            busy_d[waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (reset) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rbusy
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = raddr[i*AW +: AW];
        assign fwd = (BYPASS != 0) && we && wb_clr && (waddr == ra)
                     && !(issue_valid && (issue_rd == ra));
        assign rbusy[i] = busy_q[ra] && (ra != '0) && !fwd;
    end

    assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with optional write bypass and busy scoreboard.
// Latency: reads combinational (zero cycles); writes land on the next rising edge.
// Backpressure: none; decode stalls itself on rbusy.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                wb_clr,
    output logic                busy_any
);

    // x0 has no storage; the array starts at index 1.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (we && (waddr == AW'(r))) begin
                regs_d[r] = wdata;
            end
            if (reset) begin
                regs_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        assign ra = raddr[i*AW +: AW];
        always_comb begin
            rd = '0;
            for (int r = 1; r < NREGS; r++) begin
                if (ra == AW'(r)) begin
                    rd = regs_q[r];
                end
            end
            if ((BYPASS != 0) && we && (waddr == ra) && (ra != '0)) begin
                rd = wdata;
            end
        end
        assign rdata[i*XLEN +: XLEN] = rd;
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .waddr       (waddr),
        .wb_clr      (wb_clr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .raddr       (raddr),
        .rbusy       (rbusy),
        .busy_any    (busy_any)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: BYPASS=1 and BYPASS=0 instances on shared inputs,
// checked every cycle against an array-based model plus directed literal cases.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        wb_clr = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  waddr = '0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic        busy_any_b, busy_any_n;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_clr(wb_clr),
        .busy_any(busy_any_b)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_clr(wb_clr),
        .busy_any(busy_any_n)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    end

    // Architectural model: state updated at each rising edge from the inputs held there.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            started = 1'b1;
        end else begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (we && wb_clr) m_busy[waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (byp && we && waddr == ra) return wdata;
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] ra);
        if (ra == 0 || !m_busy[ra]) return 1'b0;
        if (byp && we && wb_clr && waddr == ra && !(issue_valid && issue_rd == ra)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_any();
        logic any = 1'b0;
        for (int i = 0; i < 32; i++) any = any | m_busy[i];
        return any;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int p = 0; p < 2; p++) begin
                logic [4:0] ra;
                ra = raddr[p*5 +: 5];
                chk($sformatf("byp_rdata%0d", p), rdata_b[p*32 +: 32], exp_data(1'b1, ra));
                chk($sformatf("nob_rdata%0d", p), rdata_n[p*32 +: 32], exp_data(1'b0, ra));
                chk($sformatf("byp_rbusy%0d", p), rbusy_b[p], exp_busy(1'b1, ra));
                chk($sformatf("nob_rbusy%0d", p), rbusy_n[p], exp_busy(1'b0, ra));
            end
            chk("byp_busy_any", busy_any_b, exp_any());
            chk("nob_busy_any", busy_any_n, exp_any());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wb_clr = 1'b0; issue_valid = 1'b0;
        issue_rd = '0; waddr = '0; wdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            raddr = {a[4:0], a[4:0]};
            #1;
            chk("rst_rdata_b", rdata_b, 64'h0);
            chk("rst_rdata_n", rdata_n, 64'h0);
            chk("rst_rbusy", {rbusy_b, rbusy_n}, 4'h0);
        end
        chk("rst_busy_any", {busy_any_b, busy_any_n}, 2'b00);
        step();

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step(); idle(); raddr = {5'd0, 5'd5};
        #1;
        chk("x5_byp", rdata_b[31:0], 32'hDEADBEEF);
        chk("x5_nob", rdata_n[31:0], 32'hDEADBEEF);
        chk("model_x5", m_regs[5], 32'hDEADBEEF);

        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        step(); idle(); raddr = {5'd0, 5'd0};
        #1;
        chk("x0_byp", rdata_b[31:0], 32'h0);
        chk("x0_nob", rdata_n[31:0], 32'h0);

        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        step();
        wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd0};
        #1;
        chk("bypass_x7_byp", rdata_b[63:32], 32'hA5A5A5A5);
        chk("bypass_x7_nob", rdata_n[63:32], 32'h11111111);
        step(); idle();

        issue_valid = 1'b1; issue_rd = 5'd3;
        step(); idle(); raddr = {5'd0, 5'd3};
        #1;
        chk("x3_busy_byp", rbusy_b[0], 1'b1);
        chk("x3_busy_nob", rbusy_n[0], 1'b1);
        chk("x3_busy_any", busy_any_b, 1'b1);
        we = 1'b1; wb_clr = 1'b1; waddr = 5'd3; wdata = 32'h33333333;
        #1;
        chk("x3_clr_mask_byp", rbusy_b[0], 1'b0);
        chk("x3_clr_nomask_nob", rbusy_n[0], 1'b1);
        chk("x3_fwd_byp", rdata_b[31:0], 32'h33333333);
        step(); idle();
        #1;
        chk("x3_done_rbusy", {rbusy_b[0], rbusy_n[0]}, 2'b00);
        chk("x3_done_any", {busy_any_b, busy_any_n}, 2'b00);
        chk("x3_data_nob", rdata_n[31:0], 32'h33333333);

        issue_valid = 1'b1; issue_rd = 5'd9;
        we = 1'b1; wb_clr = 1'b1; waddr = 5'd9; wdata = 32'h99;
        raddr = {5'd0, 5'd9};
        step(); idle();
        #1;
        chk("x9_set_wins_byp", rbusy_b[0], 1'b1);
        chk("x9_set_wins_nob", rbusy_n[0], 1'b1);
        chk("model_x9_busy", m_busy[9], 1'b1);
        we = 1'b1; wb_clr = 1'b1; waddr = 5'd9; wdata = 32'h999;
        step(); idle();
        issue_valid = 1'b1; issue_rd = 5'd0;
        step(); idle();
        #1;
        chk("x0_issue_any", {busy_any_b, busy_any_n}, 2'b00);

        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_rd = 5'd6; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        step(); idle();
        #1;
        chk("x4x6_any", {busy_any_b, busy_any_n}, 2'b11);
        reset = 1'b1; we = 1'b1; waddr = 5'd10; wdata = 32'hAAAA;
        issue_valid = 1'b1; issue_rd = 5'd12;
        step(); reset = 1'b0; idle(); raddr = {5'd6, 5'd4};
        #1;
        chk("midrst_data_byp", rdata_b, 64'h0);
        chk("midrst_data_nob", rdata_n, 64'h0);
        chk("midrst_rbusy", {rbusy_b, rbusy_n}, 4'h0);
        chk("midrst_any", {busy_any_b, busy_any_n}, 2'b00);
        raddr = {5'd12, 5'd10};
        #1;
        chk("midrst_x10", rdata_n[31:0], 32'h0);
        chk("midrst_x12_busy", rbusy_n[1], 1'b0);
        step();

        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            we          = $urandom_range(0, 1);
            waddr       = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wdata       = $urandom;
            wb_clr      = $urandom_range(0, 1);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            raddr[4:0]  = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 7));
            raddr[9:5]  = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
            step();
        end

        reset = 1'b0; idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
